// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator and its LFSR.
package bounce_gen_pkg;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int                CNT_W     = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module lfsr16
  import bounce_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;
  logic [LFSR_W-1:0] state_next;
  logic [LFSR_W-1:0] seed_eff;

  assign seed_eff = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

  // The bit shifted out of position 0 is fed back into every tapped position.
  for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_bit
    if (gi == LFSR_W - 1) begin : g_top
      assign state_next[gi] = state_reg[0] & LFSR_TAPS[gi];
    end else begin : g_mid
      assign state_next[gi] = state_reg[gi+1] ^ (state_reg[0] & LFSR_TAPS[gi]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= seed_eff;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: every level change on in produces a random toggle burst on out.
// Define BOUNCE_GEN_STATS_EN to implement the toggle_cnt statistic; otherwise it reads 0.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0]  BOUNCE_LEN = 8'd200,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = BOUNCE_LEN - CNT_W'(1);

  state_t            state_reg, state_next;
  logic              in_q_reg;
  logic              target_reg, target_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              out_reg, out_next;
  logic              busy_reg;
  logic              restart;
  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-2:0] lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (SEED),
    .state (lfsr_state)
  );

  // Only bit 0 drives the toggle decision.
  assign lfsr_unused = lfsr_state[LFSR_W-1:1];

  // A new level, whether from IDLE or as a reversal mid-window, always restarts the window.
  assign restart = (in_q_reg != target_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      in_q_reg   <= 1'b0;
      target_reg <= 1'b0;
      cnt_reg    <= '0;
      out_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      in_q_reg   <= in;
      target_reg <= target_next;
      cnt_reg    <= cnt_next;
      out_reg    <= out_next;
      busy_reg   <= (state_next == BOUNCE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    cnt_next    = cnt_reg;
    out_next    = out_reg;
    if (restart) begin
      target_next = in_q_reg;
      out_next    = in_q_reg;
      cnt_next    = '0;
      state_next  = BOUNCE;
    end else if (state_reg == BOUNCE) begin
      if (cnt_reg == CNT_LAST) begin
        out_next   = target_reg;
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (lfsr_state[0]) begin
          out_next = ~out_reg;
        end
      end
    end
  end

  assign out  = out_reg;
  assign busy = busy_reg;

`ifdef BOUNCE_GEN_STATS_EN
  logic [CNT_W-1:0] toggle_cnt_reg;
  logic             toggle_hit;

  assign toggle_hit = (state_reg == BOUNCE) && !restart && (cnt_reg != CNT_LAST) && lfsr_state[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_cnt_reg <= '0;
    end else if (restart) begin
      toggle_cnt_reg <= '0;
    end else if (toggle_hit && (toggle_cnt_reg != '1)) begin
      toggle_cnt_reg <= toggle_cnt_reg + CNT_W'(1);
    end
  end

  assign toggle_cnt = toggle_cnt_reg;
`else
  assign toggle_cnt = '0;
`endif

endmodule
